fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the FPGA processor. It replaces the hard-wired 8-bit PC register / IR register pair with one block. The block owns the program counter and drives the instruction-RAM address. It absorbs the synchronous RAM read latency, captures the fetched word into the instruction register, and presents it to the control unit through a valid/ready handshake. It also supports jumps, halt, and a clock-enable, so the whole core can run on the board clock with the divided clock used as an enable.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/param_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and limits for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/param_reg.sv
// Generic register with clock-enable, synchronous clear, load and increment.
// Priority: clear, then load, then increment.
module param_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             we,
  input  logic             inc,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (we) begin
      q_d = wdata;
    end else if (inc) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, hides instruction-RAM latency and
// hands the fetched word to the control unit over a valid/ready handshake.
//
// state | meaning
// ISSUE | drive mem_addr from pc; start a read unless halted
// WAIT  | count down the RAM latency, capture the word on the last cycle
// VALID | hold ins until the control unit accepts it
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              halt,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [1:0]        state_dbg
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_lat_range
    $error("fetch_unit: MEM_LAT must be in 1..4");
  end

  fetch_state_e      state_d, state_q;
  logic [LAT_W-1:0]  lat_cnt_d, lat_cnt_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic              ins_valid_d, ins_valid_q;
  logic              capture;
  logic [ADDR_W-1:0] pc;

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    mem_addr_d  = mem_addr_q;
    ins_valid_d = ins_valid_q;
    capture     = 1'b0;
    if (pc_load) begin
      // A jump discards whatever is in flight or pending.
      state_d     = ISSUE;
      lat_cnt_d   = '0;
      ins_valid_d = 1'b0;
    end else begin
      case (state_q)
        ISSUE: begin
          mem_addr_d = pc;
          if (!halt) begin
            state_d   = WAIT;
            lat_cnt_d = LAT_W'(MEM_LAT);
          end
        end
        WAIT: begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
          if (lat_cnt_q <= LAT_W'(1)) begin
            lat_cnt_d   = '0;
            capture     = 1'b1;
            ins_valid_d = 1'b1;
            state_d     = VALID;
          end
        end
        VALID: begin
          if (ins_ready) begin
            ins_valid_d = 1'b0;
            state_d     = ISSUE;
          end
        end
        default: begin
          state_d     = ISSUE;
          lat_cnt_d   = '0;
          ins_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ISSUE;
      lat_cnt_q   <= '0;
      mem_addr_q  <= RESET_PC;
      ins_valid_q <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_addr_q  <= mem_addr_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  param_reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .clr   (1'b0),
    .we    (pc_load),
    .inc   (capture),
    .wdata (pc_target),
    .q     (pc)
  );

  param_reg #(
    .WIDTH     (DATA_W),
    .RESET_VAL ('0)
  ) u_ins (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .clr   (1'b0),
    .we    (capture),
    .inc   (1'b0),
    .wdata (mem_rdata),
    .q     (ins)
  );

  // ins_pc comes from the address actually presented to the RAM.
  param_reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL ('0)
  ) u_ins_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .clr   (1'b0),
    .we    (capture),
    .inc   (1'b0),
    .wdata (mem_addr_q),
    .q     (ins_pc)
  );

  assign mem_addr  = mem_addr_q;
  assign ins_valid = ins_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (MEM_LAT=1 at 8'h10, MEM_LAT=3 at 0)
// share stimulus and are compared every cycle with an event-scheduling model.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       halt;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       ins_ready;

  logic [7:0] a_mem_addr, a_mem_rdata, a_ins, a_ins_pc;
  logic       a_ins_valid;
  logic [1:0] a_state_dbg;
  logic [7:0] b_mem_addr, b_mem_rdata, b_ins, b_ins_pc;
  logic       b_ins_valid;
  logic [1:0] b_state_dbg;

  logic [7:0] ram [256];

  int total = 0;
  int bad   = 0;

  // Reference model: a fetch is an event scheduled to land at a cycle index.
  int         lat_of [2] = '{1, 3};
  logic [7:0] rpc_of [2] = '{8'h10, 8'h00};
  logic [7:0] m_pc [2], m_addr [2], m_ins [2], m_ins_pc [2];
  bit         m_valid [2];
  int         m_due [2];
  int         now;

  fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h10), .MEM_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .pc_load(pc_load),
    .pc_target(pc_target), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata),
    .ins(a_ins), .ins_pc(a_ins_pc), .ins_valid(a_ins_valid),
    .ins_ready(ins_ready), .state_dbg(a_state_dbg));

  fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .MEM_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .pc_load(pc_load),
    .pc_target(pc_target), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .ins(b_ins), .ins_pc(b_ins_pc), .ins_valid(b_ins_valid),
    .ins_ready(ins_ready), .state_dbg(b_state_dbg));

  // RAM address is stable for the whole read, so a direct lookup models any latency.
  assign a_mem_rdata = ram[a_mem_addr];
  assign b_mem_rdata = ram[b_mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mstate(int k);
    if (m_valid[k]) return 2;
    if (m_due[k] >= 0) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = rpc_of[k]; m_addr[k] = rpc_of[k];
      m_ins[k] = 8'h00; m_ins_pc[k] = 8'h00;
      m_valid[k] = 1'b0; m_due[k] = -1;
    end
    now = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (pc_load) begin
        m_pc[k] = pc_target; m_due[k] = -1; m_valid[k] = 1'b0;
      end else if (m_valid[k]) begin
        if (ins_ready) m_valid[k] = 1'b0;
      end else if (m_due[k] >= 0) begin
        if (m_due[k] == now) begin
          m_ins[k] = ram[m_addr[k]]; m_ins_pc[k] = m_addr[k];
          m_pc[k] = m_pc[k] + 8'd1; m_valid[k] = 1'b1; m_due[k] = -1;
        end
      end else begin
        m_addr[k] = m_pc[k];
        if (!halt) m_due[k] = now + lat_of[k];
      end
    end
    now++;
  endtask

  task automatic check_all();
    chk("a_mem_addr", a_mem_addr, m_addr[0]);
    chk("a_ins", a_ins, m_ins[0]);
    chk("a_ins_pc", a_ins_pc, m_ins_pc[0]);
    chk("a_ins_valid", a_ins_valid, m_valid[0]);
    chk("a_state_dbg", a_state_dbg, mstate(0));
    chk("b_mem_addr", b_mem_addr, m_addr[1]);
    chk("b_ins", b_ins, m_ins[1]);
    chk("b_ins_pc", b_ins_pc, m_ins_pc[1]);
    chk("b_ins_valid", b_ins_valid, m_valid[1]);
    chk("b_state_dbg", b_state_dbg, mstate(1));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n && clk_en) model_step();
    #1;
    check_all();
  endtask

  initial begin
    int         a_seen, b_first, n;
    int         a_t [3];
    logic [7:0] a_pcs [3];
    logic [7:0] pcs [2];
    logic [7:0] a_first_ins, b_first_ins, e_ins, e_ins_pc, e_addr, held;

    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    rst_n = 1'b0; clk_en = 1'b1; halt = 1'b0; pc_load = 1'b0;
    pc_target = 8'h00; ins_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_a_addr", a_mem_addr, 8'h10);
    chk("reset_b_addr", b_mem_addr, 8'h00);

    // Startup stream with ins_ready tied high.
    @(negedge clk) rst_n = 1'b1;
    a_seen = 0; b_first = 0; a_first_ins = 8'h00; b_first_ins = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (a_ins_valid && a_seen < 3) begin
        if (a_seen == 0) a_first_ins = a_ins;
        a_pcs[a_seen] = a_ins_pc; a_t[a_seen] = i; a_seen++;
      end
      if (b_ins_valid && b_first == 0) begin
        b_first = i; b_first_ins = b_ins;
      end
    end
    chk("a_seen_count", a_seen, 3);
    if (a_seen == 3) begin
      chk("a_first_pc", a_pcs[0], 8'h10);
      chk("a_second_pc", a_pcs[1], 8'h11);
      chk("a_third_pc", a_pcs[2], 8'h12);
      chk("a_first_ins", a_first_ins, ram[8'h10]);
      chk("a_period_1", a_t[1] - a_t[0], 3);
      chk("a_period_2", a_t[2] - a_t[1], 3);
    end
    chk("b_first_latency", b_first, 4);
    chk("b_first_ins", b_first_ins, ram[8'h00]);

    // Backpressure on instance A.
    ins_ready = 1'b0;
    n = 0;
    while (!m_valid[0] && n < 20) begin cyc(); n++; end
    chk("bp_wait_valid", a_ins_valid, 1'b1);
    e_ins = m_ins[0]; e_ins_pc = m_ins_pc[0]; e_addr = m_addr[0];
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold_ins", a_ins, e_ins);
      chk("bp_hold_ins_pc", a_ins_pc, e_ins_pc);
      chk("bp_hold_valid", a_ins_valid, 1'b1);
      chk("bp_hold_addr", a_mem_addr, e_addr);
    end
    ins_ready = 1'b1;
    cyc();
    cyc();
    chk("bp_next_addr", a_mem_addr, e_ins_pc + 8'd1);

    // Jump while B is waiting on the RAM; its in-flight word must vanish.
    n = 0;
    while (mstate(1) != 1 && n < 20) begin cyc(); n++; end
    chk("jw_in_wait", b_state_dbg, 2'd1);
    pc_load = 1'b1; pc_target = 8'hA0;
    cyc();
    pc_load = 1'b0;
    n = 0;
    for (int j = 0; j < 2; j++) begin
      pcs[j] = 8'h00;
      do begin cyc(); n++; end while (!b_ins_valid && n < 40);
      pcs[j] = b_ins_pc;
    end
    chk("jw_first_pc", pcs[0], 8'hA0);
    chk("jw_second_pc", pcs[1], 8'hA1);

    // Jump on the handshake cycle in VALID, then PC wrap.
    n = 0;
    while (!a_ins_valid && n < 20) begin cyc(); n++; end
    chk("jv_in_valid", a_ins_valid, 1'b1);
    pc_load = 1'b1; pc_target = 8'hFF;
    cyc();
    pc_load = 1'b0;
    chk("jv_valid_dropped", a_ins_valid, 1'b0);
    n = 0;
    for (int j = 0; j < 2; j++) begin
      do begin cyc(); n++; end while (!a_ins_valid && n < 20);
      pcs[j] = a_ins_pc;
    end
    chk("jv_first_pc", pcs[0], 8'hFF);
    chk("jv_wrap_pc", pcs[1], 8'h00);

    // Halt: drain, confirm nothing new issues, then resume.
    halt = 1'b1;
    repeat (10) cyc();
    held = m_pc[0];
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("halt_addr", a_mem_addr, held);
      chk("halt_state", a_state_dbg, 2'd0);
    end
    halt = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!a_ins_valid && n < 10);
    chk("halt_resume_pc", a_ins_pc, held);
    chk("halt_resume_lat", n, 2);

    // clk_en asserted one cycle in four.
    for (int i = 0; i < 48; i++) begin
      clk_en = (i % 4 == 0);
      ins_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    clk_en = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      clk_en    = ($urandom_range(0, 3) != 0);
      ins_ready = 1'($urandom_range(0, 1));
      halt      = ($urandom_range(0, 7) == 0);
      pc_load   = ($urandom_range(0, 15) == 0);
      pc_target = 8'($urandom);
      cyc();
    end
    clk_en = 1'b1; halt = 1'b0; pc_load = 1'b0; ins_ready = 1'b1;

    // Asynchronous reset in the middle of a fetch.
    n = 0;
    while (mstate(1) != 1 && n < 20) begin cyc(); n++; end
    chk("rst_in_wait", b_state_dbg, 2'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_b_valid", b_ins_valid, 1'b0);
    chk("rst_b_state", b_state_dbg, 2'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
